// File: rtl/imem_loader.sv
// Instruction memory loader: packs a valid/ready byte stream into 32-bit
// little-endian words, writes them to consecutive word addresses from 0 and
// raises start_o once the requested number of words has been written.
//
// state | meaning
// IDLE  | waiting for load_req_i; no bytes accepted
// LOAD  | accepting bytes, assembling words and issuing writes
// DONE  | all words written; start_o held high for the CPU
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_req_i,
  input  logic [CNT_W-1:0] wlen_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wlen_q;
  logic [CNT_W-1:0] idx;
  logic [1:0]       lane;
  logic [23:0]      word_buf;

  logic len_ok;
  logic byte_take;
  logic last_word;

  assign len_ok    = (wlen_i != '0) && (wlen_i <= CNT_W'(DEPTH));
  assign byte_take = (state == LOAD) && byte_valid_i && byte_ready_o;
  assign last_word = (idx == (wlen_q - CNT_W'(1)));

  // Load sequencing, byte packing and registered write/status outputs.
  // A load request takes priority over a byte arriving on the same edge,
  // so an abort always drops the partial word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      wlen_q       <= '0;
      idx          <= '0;
      lane         <= 2'd0;
      word_buf     <= '0;
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      start_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      if (load_req_i) begin
        idx  <= '0;
        lane <= 2'd0;
        if (len_ok) begin
          state        <= LOAD;
          wlen_q       <= wlen_i;
          err_o        <= 1'b0;
          busy_o       <= 1'b1;
          done_o       <= 1'b0;
          start_o      <= 1'b0;
          byte_ready_o <= 1'b1;
        end else begin
          state        <= IDLE;
          err_o        <= 1'b1;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
          start_o      <= 1'b0;
          byte_ready_o <= 1'b0;
        end
      end else if (byte_take) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    word_buf[7:0]   <= byte_i;
          2'd1:    word_buf[15:8]  <= byte_i;
          2'd2:    word_buf[23:16] <= byte_i;
          default: ;
        endcase
        if (lane == 2'd3) begin
          mem_we_o   <= 1'b1;
          mem_addr_o <= 32'({idx, 2'b00});
          mem_data_o <= {byte_i, word_buf};
          idx        <= idx + CNT_W'(1);
          if (last_word) begin
            state        <= DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            start_o      <= 1'b1;
            byte_ready_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule
